// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl: two-requester command sequencer for a WIDTH-bit up/down
// count register. A round-robin arbiter accepts one clear/load/up-N/down-N
// command at a time. The FSM then steps the register once per cycle and pulses
// the owning requester's done output. The register holds its value whenever
// no step is commanded.
module updown_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    output logic             a_done,
    input  logic             b_valid,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             b_done,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             owner,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rem_r;
    logic             dir_r;
    logic             owner_r;
    logic             prio_r;
    logic             wrap_r;

    logic             grant_a_s;
    logic             grant_b_s;
    logic             accept_s;
    logic [1:0]       acc_op_s;
    logic [WIDTH-1:0] acc_data_s;

    // Round-robin arbitration: grants only in IDLE and never while reset is asserted.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (rst && (state_r == ST_IDLE)) begin
            if (a_valid && b_valid) begin
                if (prio_r) begin
                    grant_b_s = 1'b1;
                end else begin
                    grant_a_s = 1'b1;
                end
            end else if (a_valid) begin
                grant_a_s = 1'b1;
            end else if (b_valid) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
            end
        end else begin
            grant_a_s = 1'b0;
        end
    end

    // Mux the winning requester's command; these are only meaningful at acceptance.
    always_comb begin
        accept_s   = grant_a_s | grant_b_s;
        acc_op_s   = 2'b00;
        acc_data_s = ZERO;
        if (grant_b_s) begin
            acc_op_s   = b_op;
            acc_data_s = b_data;
        end else begin
            acc_op_s   = a_op;
            acc_data_s = a_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: zero-step counts skip RUN and complete like clear/load.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (acc_op_s[1] && (acc_data_s != ZERO)) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rem_r == ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: count register, step counter, direction, owner, round-robin pointer, wrap flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r     <= ZERO;
            rem_r   <= ZERO;
            dir_r   <= 1'b0;
            owner_r <= 1'b0;
            prio_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r <= grant_b_s;
                        case (acc_op_s)
                            2'b00:   q_r <= ZERO;
                            2'b01:   q_r <= acc_data_s;
                            default: begin
                                rem_r <= acc_data_s;
                                dir_r <= acc_op_s[0];
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (dir_r) begin
                        q_r    <= q_r - ONE;
                        wrap_r <= (q_r == ZERO);
                    end else begin
                        q_r    <= q_r + ONE;
                        wrap_r <= (q_r == ALL_ONES);
                    end
                    rem_r <= rem_r - ONE;
                end
                ST_DONE: prio_r <= ~owner_r;
                default: prio_r <= prio_r;
            endcase
        end
    end

    // FSM output decode; everything except the readys comes straight from registers.
    always_comb begin
        a_ready = grant_a_s;
        b_ready = grant_b_s;
        busy    = (state_r != ST_IDLE);
        a_done  = (state_r == ST_DONE) && !owner_r;
        b_done  = (state_r == ST_DONE) && owner_r;
        q       = q_r;
        owner   = owner_r;
        wrap    = wrap_r;
    end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Self-checking bench for updown_count_ctrl: a command table with a completion
// scoreboard, plus hand-written sequences for stepping/wrap, input stability,
// contention and reset-abort.
module tb_updown_count_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid;
    logic [1:0] a_op, b_op;
    logic [3:0] a_data, b_data;
    logic       a_ready, b_ready, a_done, b_done;
    logic [3:0] q;
    logic       busy, owner, wrap;

    int checks = 0;
    int failures = 0;

    updown_count_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_op(a_op), .a_data(a_data), .a_ready(a_ready), .a_done(a_done),
        .b_valid(b_valid), .b_op(b_op), .b_data(b_data), .b_ready(b_ready), .b_done(b_done),
        .q(q), .busy(busy), .owner(owner), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       req;
        bit [1:0] op;
        bit [3:0] data;
        bit [3:0] exp_q;
        int       exp_lat;
        int       exp_wraps;
    } vec_t;

    typedef struct {
        bit       owner;
        bit [3:0] q;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a command at a negedge, check it is granted, hold it across E0.
    task automatic start_cmd(input bit req, input bit [1:0] op, input bit [3:0] data);
        @(negedge clk);
        if (req) begin b_valid = 1'b1; b_op = op; b_data = data; end
        else     begin a_valid = 1'b1; a_op = op; a_data = data; end
        #1;
        chk(req ? "b_ready" : "a_ready", req ? b_ready : a_ready, 1);
        chk(req ? "a_ready_idle" : "b_ready_idle", req ? a_ready : b_ready, 0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Wait (bounded) for a done pulse, then pop the scoreboard and compare.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_wraps);
        int lat;
        int wraps;
        bit seen;
        exp_t e;
        lat = 0; wraps = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (wrap) wraps++;
            if (a_done || b_done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (seen) begin
                chk({tag, "_q"}, q, e.q);
                chk({tag, "_owner"}, owner, e.owner);
                chk({tag, "_done_a"}, a_done, !e.owner);
                chk({tag, "_done_b"}, b_done, e.owner);
                chk({tag, "_lat"}, lat, exp_lat);
                chk({tag, "_wraps"}, wraps, exp_wraps);
            end
        end
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_done_clear"}, a_done | b_done, 0);
    endtask

    task automatic run_cmd(input string tag, input bit req, input bit [1:0] op, input bit [3:0] data,
                           input bit [3:0] exp_q, input int exp_lat, input int exp_wraps);
        exp_t e;
        e.owner = req;
        e.q     = exp_q;
        sb.push_back(e);
        start_cmd(req, op, data);
        wait_done(tag, exp_lat, exp_wraps);
    endtask

    initial begin
        bit [3:0] seq_q[4];
        bit       seq_w[4];
        int       ndone;
        exp_t     e;

        // req, op, data, expected q, latency (negedges after E0 until done), wrap pulses
        vecs[0] = '{1'b0, 2'b01, 4'h9, 4'h9, 1, 0};   // load 9
        vecs[1] = '{1'b0, 2'b01, 4'hE, 4'hE, 1, 0};   // load 14
        vecs[2] = '{1'b1, 2'b10, 4'h3, 4'h1, 4, 1};   // up 3: 15,0,1
        vecs[3] = '{1'b0, 2'b11, 4'h2, 4'hF, 3, 1};   // down 2: 0,15
        vecs[4] = '{1'b1, 2'b10, 4'h0, 4'hF, 1, 0};   // up 0: no change
        vecs[5] = '{1'b0, 2'b00, 4'h7, 4'h0, 1, 0};   // clear
        vecs[6] = '{1'b1, 2'b11, 4'hF, 4'h1, 16, 1};  // down 15 from 0
        vecs[7] = '{1'b0, 2'b10, 4'hF, 4'h0, 16, 1};  // up 15 from 1
        vecs[8] = '{1'b1, 2'b01, 4'h5, 4'h5, 1, 0};   // load 5

        a_valid = 1'b1; b_valid = 1'b1;
        a_op = 2'b01; b_op = 2'b01; a_data = 4'h3; b_data = 4'h4;
        rst = 1'b0;

        // Reset: readys low while rst=0, all state cleared.
        repeat (2) @(negedge clk);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", a_done | b_done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_owner", owner, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;

        // Command table.
        foreach (vecs[i]) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].req, vecs[i].op, vecs[i].data,
                    vecs[i].exp_q, vecs[i].exp_lat, vecs[i].exp_wraps);
        end

        // Per-step q/wrap trace for B up 3 from 14, with B's op/data changed mid-RUN.
        run_cmd("ld14", 1'b0, 2'b01, 4'hE, 4'hE, 1, 0);
        seq_q = '{4'hE, 4'hF, 4'h0, 4'h1};
        seq_w = '{1'b0, 1'b0, 1'b1, 1'b0};
        start_cmd(1'b1, 2'b10, 4'h3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("trace_q%0d", k), q, seq_q[k]);
            chk($sformatf("trace_wrap%0d", k), wrap, seq_w[k]);
            chk($sformatf("trace_busy%0d", k), busy, 1);
            chk($sformatf("trace_bdone%0d", k), b_done, (k == 3) ? 1 : 0);
            if (k == 0) begin
                b_op = 2'b11; b_data = 4'h9; a_op = 2'b00; a_data = 4'h2;
            end
        end
        @(negedge clk);
        chk("trace_busy_end", busy, 0);
        chk("trace_q_end", q, 1);

        // Contention: B served last so prio points at A; expect A,B,A,B from q=5.
        run_cmd("ld5", 1'b1, 2'b01, 4'h5, 4'h5, 1, 0);
        e.owner = 1'b0; e.q = 4'h6; sb.push_back(e);
        e.owner = 1'b1; e.q = 4'h5; sb.push_back(e);
        e.owner = 1'b0; e.q = 4'h6; sb.push_back(e);
        e.owner = 1'b1; e.q = 4'h5; sb.push_back(e);
        @(negedge clk);
        a_valid = 1'b1; a_op = 2'b10; a_data = 4'h1;
        b_valid = 1'b1; b_op = 2'b11; b_data = 4'h1;
        #1;
        chk("rr_first_a_ready", a_ready, 1);
        chk("rr_first_b_ready", b_ready, 0);
        ndone = 0;
        for (int i = 0; i < 60 && ndone < 4; i++) begin
            @(negedge clk);
            if (a_done || b_done) begin
                e = sb.pop_front();
                chk($sformatf("rr%0d_owner", ndone), owner, e.owner);
                chk($sformatf("rr%0d_doneb", ndone), b_done, e.owner);
                chk($sformatf("rr%0d_q", ndone), q, e.q);
                ndone++;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("rr_count", ndone, 4);
        @(negedge clk);

        // Reset mid-RUN aborts A up 10 without a done pulse.
        run_cmd("clr", 1'b1, 2'b00, 4'h0, 4'h0, 1, 0);
        start_cmd(1'b0, 2'b10, 4'hA);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mid_q_before", q, 4);
        rst = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_op = 2'b01; a_data = 4'h3;
        #1;
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_b_ready", b_ready, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("mid_q%0d", k), q, 0);
            chk($sformatf("mid_busy%0d", k), busy, 0);
            chk($sformatf("mid_done%0d", k), a_done | b_done, 0);
            chk($sformatf("mid_wrap%0d", k), wrap, 0);
            chk($sformatf("mid_owner%0d", k), owner, 0);
        end
        rst = 1'b1;
        #1;
        chk("post_rst_prio_a", a_ready, 1);
        chk("post_rst_prio_b", b_ready, 0);
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_load_q", q, 3);
        chk("post_rst_adone", a_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
